// File: rtl/palette_pkg.sv
// Shared palette definitions: colour type, chroma key, bank names and constant palette tables.
// Entry 0 of each bank is the chroma key so sprite backgrounds render transparent.
package palette_pkg;

  localparam int unsigned PAL_BANKS  = 4;
  localparam int unsigned PAL_BANK_W = 2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t CHROMA_KEY = 12'hF0F;

  typedef enum logic [1:0] {
    BankHeadA = 2'd0,
    BankHeadB = 2'd1,
    BankBody  = 2'd2,
    BankFood  = 2'd3
  } bank_e;

  localparam rgb12_t PALETTES [PAL_BANKS][16] = '{
    '{12'hF0F, 12'h2C7, 12'h1A5, 12'h083, 12'h062, 12'h041, 12'hFFF, 12'h000,
      12'hEE2, 12'hCC1, 12'h3D8, 12'h4E9, 12'h5FA, 12'h111, 12'h222, 12'h333},
    '{12'hF0F, 12'h27C, 12'h15A, 12'h038, 12'h026, 12'h014, 12'hFFF, 12'h000,
      12'hE2E, 12'hC1C, 12'h38D, 12'h49E, 12'h5AF, 12'h444, 12'h555, 12'h666},
    '{12'hF0F, 12'h8B4, 12'h7A3, 12'h692, 12'h581, 12'h470, 12'h9C5, 12'hAD6,
      12'hBE7, 12'hCF8, 12'h360, 12'h250, 12'h140, 12'h777, 12'h888, 12'h999},
    '{12'hF0F, 12'hE21, 12'hF0F, 12'hC10, 12'hF84, 12'hD63, 12'hB42, 12'h3A2,
      12'h291, 12'hFD0, 12'hEC0, 12'hDB0, 12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD}
  };

  // Address is {bank, index}; anything past the stored banks reads as black.
  function automatic rgb12_t pal_read(logic [15:0] addr);
    rgb12_t v;
    v = '0;
    if (addr < 16'(PAL_BANKS * 16)) begin
      v = PALETTES[addr[PAL_BANK_W+3:4]][addr[3:0]];
    end
    return v;
  endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Request/grant/response bundle between sprite renderers (master) and the lookup arbiter (slave).
interface palette_lookup_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ID_W      = $clog2(NUM_REQ),
    parameter int unsigned BANK_W    = $clog2(NUM_BANKS)
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*4-1:0]      req_index;
    logic [NUM_REQ*BANK_W-1:0] req_bank;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [3:0]                rsp_red;
    logic [3:0]                rsp_green;
    logic [3:0]                rsp_blue;
    logic                      rsp_transparent;

    modport master (
        output req, req_index, req_bank,
        input  gnt, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
    );

    modport slave (
        input  req, req_index, req_bank,
        output gnt, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant is combinational from req and the pointer, which
// remembers the last winner so the search restarts just after it.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [ID_W-1:0]    gnt_id_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] gnt_id;
    logic            found;

    // Candidates are visited ptr+1, ptr+2, ... modulo NUM_REQ; first requester wins.
    always_comb begin
        gnt_o  = '0;
        found  = 1'b0;
        gnt_id = ptr_q;
        sum    = '0;
        cand   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(off);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_id       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = found ? gnt_id : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_valid_o = found;
    assign gnt_id_o    = gnt_id;

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared palette lookup port: round-robin grant, two-cycle registered RGB response tagged with id.
// Build option TRANSPARENT_KEY_EN adds a registered chroma-key flag; otherwise it is tied low.
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ID_W      = $clog2(NUM_REQ),
    parameter int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    palette_lookup_arbiter_if.slave  bus
);

    logic            grant_valid;
    logic [ID_W-1:0] grant_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .req_i       (bus.req),
        .gnt_o       (bus.gnt),
        .gnt_valid_o (grant_valid),
        .gnt_id_o    (grant_id)
    );

    // Stage 0: capture the granted request.
    logic              s0_valid_q, s0_valid_d;
    logic [ID_W-1:0]   s0_id_q, s0_id_d;
    logic [3:0]        s0_index_q, s0_index_d;
    logic [BANK_W-1:0] s0_bank_q, s0_bank_d;

    always_comb begin
        s0_valid_d = grant_valid;
        s0_id_d    = s0_id_q;
        s0_index_d = s0_index_q;
        s0_bank_d  = s0_bank_q;
        if (grant_valid) begin
            s0_id_d    = grant_id;
            s0_index_d = bus.req_index[32'(grant_id) * 4 +: 4];
            s0_bank_d  = bus.req_bank[32'(grant_id) * BANK_W +: BANK_W];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s0_valid_q <= 1'b0;
            s0_id_q    <= '0;
            s0_index_q <= '0;
            s0_bank_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_id_q    <= s0_id_d;
            s0_index_q <= s0_index_d;
            s0_bank_q  <= s0_bank_d;
        end
    end

    logic [BANK_W+3:0] lookup_addr;
    logic              bank_ok;
    rgb12_t            lookup_rgb;

    always_comb begin
        lookup_addr = {s0_bank_q, s0_index_q};
        bank_ok     = 32'(s0_bank_q) < NUM_BANKS;
        lookup_rgb  = bank_ok ? pal_read(16'(lookup_addr)) : '0;
    end

    // Output stage: id/rgb only load with a valid entry so they hold while idle.
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    rgb12_t          rsp_rgb_q, rsp_rgb_d;

    always_comb begin
        rsp_valid_d = s0_valid_q;
        rsp_id_d    = s0_valid_q ? s0_id_q : rsp_id_q;
        rsp_rgb_d   = s0_valid_q ? lookup_rgb : rsp_rgb_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rgb_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rgb_q   <= rsp_rgb_d;
        end
    end

`ifdef TRANSPARENT_KEY_EN
    logic rsp_transparent_q, rsp_transparent_d;

    always_comb begin
        rsp_transparent_d = s0_valid_q ? (lookup_rgb == CHROMA_KEY) : rsp_transparent_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_transparent_q <= 1'b0;
        end else begin
            rsp_transparent_q <= rsp_transparent_d;
        end
    end

    assign bus.rsp_transparent = rsp_transparent_q;
`else
    assign bus.rsp_transparent = 1'b0;
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_red   = rsp_rgb_q.r;
    assign bus.rsp_green = rsp_rgb_q.g;
    assign bus.rsp_blue  = rsp_rgb_q.b;

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Shares one registered palette-lookup port between NUM_REQ sprite renderers (snake heads, bodies, food) in the VGA pixel path.
- Each request carries a 4-bit colour index and a palette bank id. The block grants one requester per cycle, round-robin.
- It returns 12-bit RGB tagged with the requester id after a fixed 2-cycle latency.
- Palette contents are constant tables held in the shared package; one bank per sprite palette.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- NUM_BANKS, 4, number of 16-entry palette banks.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- BANK_W, $clog2(NUM_BANKS), width of the bank select.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester lookup request.
- req_index  input  NUM_REQ*4  packed colour indices; slot i = bits [4i+3:4i].
- req_bank  input  NUM_REQ*BANK_W  packed bank selects per requester.
- gnt  output  NUM_REQ  one-hot grant; combinational from req and the RR pointer.
- rsp_valid  output  1  response valid (registered).
- rsp_id  output  ID_W  requester that owns the response.
- rsp_red / rsp_green / rsp_blue  output  4 each  looked-up colour.
- rsp_transparent  output  1  entry equals chroma key 12'hF0F.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_rgb=0, rsp_transparent=0, stage-0 valid=0, RR pointer=NUM_REQ-1 (requester 0 has first priority).
- Grant: gnt is one-hot or zero. The search starts at pointer+1 and wraps modulo NUM_REQ. gnt[i] is only ever high where req[i]=1.
- Pointer update: on any grant, the pointer loads the granted index. With no request, the pointer holds.
- Handshake: a requester holds req, index and bank stable until it sees gnt. Dropping req before gnt is legal and causes no transaction. Each gnt cycle is exactly one accepted lookup. A requester may keep req high for back-to-back lookups.
- Pipeline, request granted in cycle t:
  - End of t: stage 0 captures valid, id, index and bank.
  - Cycle t+1: combinational table lookup.
  - End of t+1: output registers load.
  - Cycle t+2: rsp_valid=1 for exactly one cycle per grant.
- No backpressure; throughput is 1 lookup per cycle.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,...,NUM_REQ-1,0,...
  - No requester waits more than NUM_REQ-1 cycles while another holds grants.
- Bank range: bank >= NUM_BANKS returns RGB 0 and transparent=0. This is not an error.
- Idle: when rsp_valid=0, rsp_id/rgb hold their last values. Consumers must gate on rsp_valid.
- Reset mid-operation: in-flight stage-0 and output entries are discarded and rsp_valid drops immediately. After release, the first grant goes to the lowest-numbered active requester.
- Width rules: the index is zero-extended by concatenation to form {bank, index}, an address of BANK_W+4 bits. No arithmetic overflow paths exist.

Optional Feature:
- TRANSPARENT_KEY_EN:
  - Defined: rsp_transparent is registered alongside RGB and is 1 when the looked-up value equals 12'hF0F.
  - Undefined: rsp_transparent is tied 0 and the compare logic is absent. RGB behaviour is identical in both builds.

Decomposition:
- Shared package palette_pkg holds:
  - typedef rgb12_t (12-bit {r,g,b});
  - constant CHROMA_KEY = 12'hF0F;
  - the constant array PALETTES[NUM_BANKS][16] of rgb12_t;
  - bank enum names (one per sprite palette).
- One natural sub-module, rr_arbiter: parameterised NUM_REQ; req in, one-hot gnt out, pointer register inside.

Test Plan:
- Reset with req=4'b1111 held: first gnt after release = 4'b0001; response id 0 appears 2 cycles later.
- All four requesting continuously for 8 cycles: gnt sequence 1,2,4,8,1,2,4,8; rsp_id sequence 0,1,2,3,0,1,2,3 offset by 2 cycles.
- Only req[2] high, index 4'h1, bank 0: gnt[2] on every cycle; rsp_valid continuously high; RGB = bank 0 entry 1 (e.g. 2,C,7 for the head palette).
- Index 4'h2 on a bank whose entry 2 = 12'hF0F: with TRANSPARENT_KEY_EN, rsp_transparent=1; without it, 0. RGB = F,0,F in both builds.
- Reset_n pulsed low one cycle after a grant: rsp_valid never rises for that request; all outputs are 0 during reset.
- req[1] raised for one cycle while req[0] wins, then dropped: no grant to 1 and no response carrying id 1.
